uart_frame_controller: RTL and testbench
========================================

// Module: uart_frame_controller
// PURPOSE
//  Full-duplex UART link controller. TX path serialises variable-length frames
//  (1..MAX_TX_BYTES bytes, MSB byte first) from the sensor core. RX path decodes
//  PC commands ('R', 'S', 'm'/'a' + address byte). RX and TX run independently.
//  Sits between the core FSM and the board RS232 pins. Instantiates the team
//  uart_tx/uart_rx byte cores with CLKS_PER_BIT.
// PARAMETERS
//  CLKS_PER_BIT     2605     i_CLK cycles per UART bit (25MHz/9600)
//  MAX_TX_BYTES     8        max frame length in bytes (>=1)
//  LEN_W            4        i_TX_LEN width; must satisfy 2**LEN_W > MAX_TX_BYTES
//  RX_TIMEOUT_CLKS  2000000  cycles allowed between command byte and address byte
// PORTS
//  i_CLK         in   1                 system clock
//  i_RST         in   1                 reset, asynchronous, active-high
//  i_TX_DATA     in   8*MAX_TX_BYTES    frame; byte0 = [8*MAX_TX_BYTES-1 -: 8]
//  i_TX_LEN      in   LEN_W             number of bytes to send from byte0
//  i_TX_VALID    in   1                 frame request
//  o_TX_READY    out  1                 controller can accept a frame
//  o_TX_ERR      out  1                 1-cycle pulse: illegal length, frame dropped
//  o_RX_CMD      out  8                 last decoded command byte
//  o_RX_ARG      out  8                 address byte ('m'/'a'), else 8'h00
//  o_RX_VALID    out  1                 1-cycle pulse: o_RX_CMD/o_RX_ARG valid
//  o_RX_ERR      out  1                 1-cycle pulse: rejected byte or arg timeout
//  i_CORE_BUSY   in   1                 core is streaming sensor data
//  i_UART_RXD    in   1                 serial in
//  o_UART_TXD    out  1                 serial out (idle high)
// BEHAVIOUR
//  Reset: o_TX_READY=0, o_TX_ERR=0, o_RX_CMD=0, o_RX_ARG=0, o_RX_VALID=0,
//   o_RX_ERR=0. Counters cleared, both FSMs go to IDLE. o_TX_READY=1 from the
//   first clock edge after i_RST falls. A reset mid-frame drops the frame; the
//   byte core may finish its current byte.
//  TX handshake: accept on edge with i_TX_VALID & o_TX_READY. The frame is
//   latched into a shift register and the length into a counter; o_TX_READY=0
//   the next cycle.
//  TX FSM: TX_IDLE -> TX_LOAD -> TX_SEND -> TX_WAIT -> TX_SEND ... -> TX_IDLE.
//   - TX_LOAD: LEN==0 or LEN>MAX_TX_BYTES: pulse o_TX_ERR, return to TX_IDLE
//     (ready again 1 cycle later). No byte is sent.
//   - TX_SEND: 1-cycle byte-core DV with shift[top byte]; decrement remaining.
//   - TX_WAIT: hold until byte-core done; then shift left 8. Remaining==0 ->
//     TX_IDLE with o_TX_READY=1 on the same edge, else TX_SEND.
//   - Back-to-back frames: next accept can occur the cycle ready returns high.
//  RX FSM: RX_IDLE, RX_ARG. Bytes arrive as the byte core's 1-cycle DV.
//   - 'S'(53h): always accepted -> CMD=53h, ARG=00h, o_RX_VALID pulse.
//   - 'R'(52h): accepted only if !i_CORE_BUSY, otherwise o_RX_ERR pulse.
//   - 'm'(6Dh)/'a'(61h): only if !i_CORE_BUSY. Latch CMD; go to RX_ARG; load
//     timeout counter. If busy: o_RX_ERR pulse.
//   - Any other byte in RX_IDLE: o_RX_ERR pulse, state unchanged.
//   - RX_ARG: next byte (any value, including 'S') -> ARG, o_RX_VALID pulse,
//     RX_IDLE. If busy rises while in RX_ARG, the command still completes.
//     Counter reaches RX_TIMEOUT_CLKS-1 without a byte -> o_RX_ERR pulse,
//     RX_IDLE, and CMD/ARG are not updated as valid.
//   - o_RX_VALID/o_RX_ERR never assert in the same cycle. Outputs are registered.
//     CMD/ARG hold until the next valid.
//  Concurrency: an RX byte and a TX accept in the same cycle are both handled.
//   The paths share no state.
// TESTING (sim CLKS_PER_BIT=4, RX_TIMEOUT_CLKS=200, MAX_TX_BYTES=8)
//  1. LEN=5, DATA={41h,01h,02h,03h,04h,...} -> TXD shows 41,01,02,03,04 in order,
//     then ready=1. Exactly 5 byte frames on the line.
//  2. LEN=3 frame; valid held high -> second frame accepted the cycle ready
//     rises, no gap byte, no lost byte.
//  3. LEN=0, then LEN=9 -> o_TX_ERR pulses once each, TXD stays high, ready=1
//     after 2 cycles.
//  4. RXD sends 6Dh,12h, busy=0 -> one o_RX_VALID, CMD=6Dh, ARG=12h.
//  5. RXD sends 61h only -> after 200 cycles, o_RX_ERR pulses, no o_RX_VALID.
//     A following 52h yields CMD=52h, ARG=00h.
//  6. busy=1: RXD 52h -> o_RX_ERR; RXD 53h -> o_RX_VALID, CMD=53h. Assert i_RST
//     mid-TX frame -> all outputs at reset values, next frame accepted cleanly.

Source files
------------

// File: rtl/uart_frame_controller.sv
// rtl/uart_frame_controller.sv - full-duplex UART link: framed TX serialiser and PC command RX decoder
// Byte cores (uart_tx / uart_rx) live in this file so the block stays self-contained.

module uart_tx #(
    parameter int CLKS_PER_BIT = 2605
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dv,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            txd   <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (dv) begin
                        shreg <= data;
                        txd   <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        txd   <= shreg[0];
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                            txd <= shreg[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // done fires only after the full stop bit has been on the line
                    if (bit_end) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module uart_rx #(
    parameter int CLKS_PER_BIT = 2605
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       dv,
    output logic [7:0] data
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          sync1;
    logic          rx;
    logic          bit_end;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            data  <= '0;
            dv    <= 1'b0;
        end else begin
            sync1 <= rxd;
            rx    <= sync1;
            dv    <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx) state <= S_START;
                end
                S_START: begin
                    // re-check the start bit mid-way so a glitch is not taken as a byte
                    if (cnt == CW'((CLKS_PER_BIT - 1) / 2)) begin
                        cnt   <= '0;
                        state <= rx ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        data[idx] <= rx;
                        if (idx == 3'd7) state <= S_STOP;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        dv    <= rx;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module uart_frame_controller #(
    parameter int CLKS_PER_BIT    = 2605,
    parameter int MAX_TX_BYTES    = 8,
    parameter int LEN_W           = 4,
    parameter int RX_TIMEOUT_CLKS = 2000000
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [8*MAX_TX_BYTES-1:0] i_TX_DATA,
    input  logic [LEN_W-1:0]          i_TX_LEN,
    input  logic                      i_TX_VALID,
    output logic                      o_TX_READY,
    output logic                      o_TX_ERR,
    output logic [7:0]                o_RX_CMD,
    output logic [7:0]                o_RX_ARG,
    output logic                      o_RX_VALID,
    output logic                      o_RX_ERR,
    input  logic                      i_CORE_BUSY,
    input  logic                      i_UART_RXD,
    output logic                      o_UART_TXD
);
    localparam int FW   = 8 * MAX_TX_BYTES;
    localparam int TO_W = $clog2(RX_TIMEOUT_CLKS + 1);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_SEND = 2'd2;
    localparam logic [1:0] TX_WAIT = 2'd3;

    localparam logic RX_IDLE = 1'b0;
    localparam logic RX_ARG  = 1'b1;

    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_M = 8'h6D;
    localparam logic [7:0] CMD_A = 8'h61;

    logic [1:0]       tx_state;
    logic [FW-1:0]    shift;
    logic [LEN_W-1:0] remaining;
    logic             byte_dv;
    logic             byte_done;

    logic             rx_state;
    logic             rx_dv;
    logic [7:0]       rx_byte;
    logic [7:0]       pend_cmd;
    logic [TO_W-1:0]  to_cnt;

    assign byte_dv = (tx_state == TX_SEND);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk  (i_CLK),
        .rst  (i_RST),
        .dv   (byte_dv),
        .data (shift[FW-1 -: 8]),
        .txd  (o_UART_TXD),
        .done (byte_done)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk  (i_CLK),
        .rst  (i_RST),
        .rxd  (i_UART_RXD),
        .dv   (rx_dv),
        .data (rx_byte)
    );

    // Ready is registered: it rises on the first idle edge after reset or a dropped frame
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            tx_state   <= TX_IDLE;
            shift      <= '0;
            remaining  <= '0;
            o_TX_READY <= 1'b0;
            o_TX_ERR   <= 1'b0;
        end else begin
            o_TX_ERR <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (o_TX_READY && i_TX_VALID) begin
                        shift      <= i_TX_DATA;
                        remaining  <= i_TX_LEN;
                        o_TX_READY <= 1'b0;
                        tx_state   <= TX_LOAD;
                    end else begin
                        o_TX_READY <= 1'b1;
                    end
                end
                TX_LOAD: begin
                    if ((remaining == '0) || (remaining > LEN_W'(MAX_TX_BYTES))) begin
                        o_TX_ERR <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    remaining <= remaining - 1'b1;
                    tx_state  <= TX_WAIT;
                end
                default: begin
                    if (byte_done) begin
                        shift <= shift << 8;
                        if (remaining == '0) begin
                            o_TX_READY <= 1'b1;
                            tx_state   <= TX_IDLE;
                        end else begin
                            tx_state <= TX_SEND;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rx_state   <= RX_IDLE;
            pend_cmd   <= '0;
            to_cnt     <= '0;
            o_RX_CMD   <= '0;
            o_RX_ARG   <= '0;
            o_RX_VALID <= 1'b0;
            o_RX_ERR   <= 1'b0;
        end else begin
            o_RX_VALID <= 1'b0;
            o_RX_ERR   <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (rx_dv) begin
                    if (rx_byte == CMD_S || (rx_byte == CMD_R && !i_CORE_BUSY)) begin
                        o_RX_CMD   <= rx_byte;
                        o_RX_ARG   <= 8'h00;
                        o_RX_VALID <= 1'b1;
                    end else if ((rx_byte == CMD_M || rx_byte == CMD_A) && !i_CORE_BUSY) begin
                        pend_cmd <= rx_byte;
                        to_cnt   <= '0;
                        rx_state <= RX_ARG;
                    end else begin
                        o_RX_ERR <= 1'b1;
                    end
                end
            end else begin
                // Busy is deliberately ignored here: an accepted command always completes
                if (rx_dv) begin
                    o_RX_CMD   <= pend_cmd;
                    o_RX_ARG   <= rx_byte;
                    o_RX_VALID <= 1'b1;
                    rx_state   <= RX_IDLE;
                end else if (to_cnt == TO_W'(RX_TIMEOUT_CLKS - 1)) begin
                    o_RX_ERR <= 1'b1;
                    rx_state <= RX_IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_controller.sv
// tb/tb_uart_frame_controller.sv - scoreboard bench for uart_frame_controller
module tb_uart_frame_controller;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tx_data;
    logic [3:0]  tx_len;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_err;
    logic [7:0]  rx_cmd;
    logic [7:0]  rx_arg;
    logic        rx_valid;
    logic        rx_err;
    logic        busy;
    logic        rxd;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int tx_byte_cnt = 0;
    int tx_err_cnt = 0;

    logic [7:0]  tx_q[$];
    logic [16:0] rx_q[$];

    always #5 clk = ~clk;

    uart_frame_controller #(
        .CLKS_PER_BIT(CPB), .MAX_TX_BYTES(8), .LEN_W(4), .RX_TIMEOUT_CLKS(200)
    ) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_TX_DATA(tx_data), .i_TX_LEN(tx_len), .i_TX_VALID(tx_valid),
        .o_TX_READY(tx_ready), .o_TX_ERR(tx_err),
        .o_RX_CMD(rx_cmd), .o_RX_ARG(rx_arg), .o_RX_VALID(rx_valid), .o_RX_ERR(rx_err),
        .i_CORE_BUSY(busy), .i_UART_RXD(rxd), .o_UART_TXD(txd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX line monitor: decodes each serial byte and pops the scoreboard
    initial begin
        int cnt;
        bit active;
        logic [7:0] b;
        cnt = 0;
        active = 0;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                cnt = 0;
            end else if (!active) begin
                if (txd == 1'b0) begin
                    active = 1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= 5 && cnt <= 33 && ((cnt - 1) % 4) == 0) b[(cnt - 5) / 4] = txd;
                if (cnt == 37) begin
                    active = 0;
                    tx_byte_cnt++;
                    check("tx_stop_bit", {31'd0, txd}, 32'd1);
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected_byte: got %0h expected none", b);
                    end else begin
                        check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                    end
                end
            end
        end
    end

    // RX event monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_err) tx_err_cnt++;
                if (rx_valid && rx_err) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_valid_err_same_cycle: got both expected one");
                end else if (rx_valid || rx_err) begin
                    if (rx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_event: got valid=%0b err=%0b cmd=%0h", rx_valid, rx_err, rx_cmd);
                    end else if (rx_valid) begin
                        check("rx_event", {15'd0, 1'b0, rx_cmd, rx_arg}, {15'd0, rx_q.pop_front()});
                    end else begin
                        check("rx_event", {15'd0, 1'b1, 16'h0000}, {15'd0, rx_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        while (!tx_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send_frame(input logic [63:0] d, input logic [3:0] l, input bit keep);
        tx_data  = d;
        tx_len   = l;
        tx_valid = 1'b1;
        wait_ready(2000);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        int b0;
        rst = 1'b1;
        tx_data = '0;
        tx_len = '0;
        tx_valid = 1'b0;
        busy = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_tx_err", {31'd0, tx_err}, 32'd0);
        check("rst_rx_cmd", {24'd0, rx_cmd}, 32'd0);
        check("rst_rx_arg", {24'd0, rx_arg}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_err", {31'd0, rx_err}, 32'd0);
        check("rst_txd_idle", {31'd0, txd}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, tx_ready}, 32'd1);

        // 5-byte frame, MSB byte first
        tx_q.push_back(8'h41); tx_q.push_back(8'h01); tx_q.push_back(8'h02);
        tx_q.push_back(8'h03); tx_q.push_back(8'h04);
        b0 = tx_byte_cnt;
        send_frame(64'h41010203_04050607, 4'd5, 0);
        check("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
        wait_ready(2000);
        check("frame5_queue_drained", tx_q.size(), 32'd0);
        check("frame5_byte_count", tx_byte_cnt - b0, 32'd5);

        // back-to-back frames with valid held high
        tx_q.push_back(8'hA1); tx_q.push_back(8'hB2); tx_q.push_back(8'hC3);
        b0 = tx_byte_cnt;
        send_frame(64'hA1B2C3D4_E5F60718, 4'd3, 1);
        tx_data = 64'h5A6B7C8D_9EAFB0C1;
        tx_q.push_back(8'h5A); tx_q.push_back(8'h6B); tx_q.push_back(8'h7C);
        wait_ready(2000);
        @(negedge clk);
        check("b2b_accept_immediate", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        wait_ready(2000);
        check("b2b_queue_drained", tx_q.size(), 32'd0);
        check("b2b_byte_count", tx_byte_cnt - b0, 32'd6);

        // illegal lengths 0 and 9
        for (int k = 0; k < 2; k++) begin
            send_frame(64'hFFFF0000_FFFF0000, (k == 0) ? 4'd0 : 4'd9, 0);
            check("badlen_ready_c1", {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
            check("badlen_err_pulse", {31'd0, tx_err}, 32'd1);
            check("badlen_ready_c2", {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
            check("badlen_err_cleared", {31'd0, tx_err}, 32'd0);
            check("badlen_ready_back", {31'd0, tx_ready}, 32'd1);
            check("badlen_txd_high", {31'd0, txd}, 32'd1);
        end
        repeat (50) @(negedge clk);
        check("tx_err_pulse_count", tx_err_cnt, 32'd2);

        // RX commands
        rx_q.push_back({1'b0, 8'h6D, 8'h12});
        send_rx(8'h6D); send_rx(8'h12);
        rx_q.push_back({1'b0, 8'h6D, 8'h53});
        send_rx(8'h6D); send_rx(8'h53);
        rx_q.push_back({1'b1, 16'h0000});
        send_rx(8'h78);
        repeat (10) @(negedge clk);
        check("rx_cmds_drained", rx_q.size(), 32'd0);

        // argument timeout
        rx_q.push_back({1'b1, 16'h0000});
        send_rx(8'h61);
        repeat (150) @(negedge clk);
        check("rx_timeout_not_early", rx_q.size(), 32'd1);
        repeat (100) @(negedge clk);
        check("rx_timeout_fired", rx_q.size(), 32'd0);
        check("rx_cmd_held", {24'd0, rx_cmd}, 32'h6D);
        rx_q.push_back({1'b0, 8'h52, 8'h00});
        send_rx(8'h52);
        repeat (10) @(negedge clk);
        check("rx_after_timeout_drained", rx_q.size(), 32'd0);

        // core busy
        busy = 1'b1;
        rx_q.push_back({1'b1, 16'h0000});
        send_rx(8'h52);
        rx_q.push_back({1'b0, 8'h53, 8'h00});
        send_rx(8'h53);
        rx_q.push_back({1'b1, 16'h0000});
        send_rx(8'h6D);
        repeat (10) @(negedge clk);
        check("rx_busy_drained", rx_q.size(), 32'd0);
        busy = 1'b0;

        // reset in the middle of a frame
        tx_q.push_back(8'hDE); tx_q.push_back(8'hAD); tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
        send_frame(64'hDEADBEEF_00000000, 4'd4, 0);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        tx_q.delete();
        @(negedge clk);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_rx_cmd", {24'd0, rx_cmd}, 32'd0);
        check("midrst_rx_arg", {24'd0, rx_arg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_back", {31'd0, tx_ready}, 32'd1);
        tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
        b0 = tx_byte_cnt;
        send_frame(64'h3CC31122_33445566, 4'd2, 0);
        wait_ready(2000);
        check("post_rst_queue_drained", tx_q.size(), 32'd0);
        check("post_rst_byte_count", tx_byte_cnt - b0, 32'd2);

        repeat (20) @(negedge clk);
        check("final_rx_queue", rx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
